// File: rtl/fa_2_adder.sv
// Ripple-carry adder with a combinational result and a 1-cycle registered result.
// Optional FA2_PARITY_EN adds o_par, the registered XOR-reduction of o_q.
module fa_2_adder #(
    parameter int WIDTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             in_valid,
    output logic [WIDTH:0]   o,
    output logic [WIDTH:0]   o_q,
`ifdef FA2_PARITY_EN
    output logic             o_par,
`endif
    output logic             out_valid
);

    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] sum;

    assign carry[0] = cin;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        logic p;
        assign p            = a[i] ^ b[i];
        assign sum[i]       = p ^ carry[i];
        assign carry[i+1]   = (a[i] & b[i]) | (carry[i] & p);
    end

    assign o = {carry[WIDTH], sum};

    logic [WIDTH:0] sum_q, sum_d;
    logic           valid_q, valid_d;

    always_comb begin
        sum_d   = sum_q;
        valid_d = in_valid;
        if (in_valid) begin
            sum_d = o;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            sum_q   <= sum_d;
            valid_q <= valid_d;
        end
    end

    assign o_q       = sum_q;
    assign out_valid = valid_q;

`ifdef FA2_PARITY_EN
    logic par_q, par_d;

    always_comb begin
        par_d = par_q;
        if (in_valid) begin
            par_d = ^o;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            par_q <= 1'b0;
        end else begin
            par_q <= par_d;
        end
    end

    assign o_par = par_q;
`endif

endmodule

// File: tb/tb_fa_2_adder.sv
// Self-checking bench for fa_2_adder: directed plan steps plus random traffic
// against an arithmetic reference model.
module tb_fa_2_adder;

    localparam int W = 2;

    logic         clk;
    logic         rst_n;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         in_valid;
    logic [W:0]   o;
    logic [W:0]   o_q;
    logic         out_valid;
`ifdef FA2_PARITY_EN
    logic         o_par;
`endif

    int checks = 0;
    int errors = 0;

    logic [W:0] exp_q;
    logic       exp_v;

    fa_2_adder #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .a        (a),
        .b        (b),
        .cin      (cin),
        .in_valid (in_valid),
        .o        (o),
        .o_q      (o_q),
`ifdef FA2_PARITY_EN
        .o_par    (o_par),
`endif
        .out_valid(out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [W:0] ref_sum(input logic [W-1:0] x,
                                           input logic [W-1:0] y,
                                           input logic c);
        int s;
        s = int'(x) + int'(y) + int'(c);
        return s[W:0];
    endfunction

    task automatic check(input string tag, input logic [7:0] obs,
                         input logic [7:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic drive(input logic [W-1:0] va, input logic [W-1:0] vb,
                         input logic vc, input logic vv);
        a        = va;
        b        = vb;
        cin      = vc;
        in_valid = vv;
    endtask

    // Drive on the falling edge, check o, then check the registered side
    // just after the following rising edge.
    task automatic cycle(input string tag, input logic [W-1:0] va,
                         input logic [W-1:0] vb, input logic vc,
                         input logic vv);
        @(negedge clk);
        drive(va, vb, vc, vv);
        #1;
        check({tag, ".o"}, 8'(o), 8'(ref_sum(va, vb, vc)));
        @(posedge clk);
        if (vv) exp_q = ref_sum(va, vb, vc);
        exp_v = vv;
        #1;
        check({tag, ".o_q"}, 8'(o_q), 8'(exp_q));
        check({tag, ".out_valid"}, 8'(out_valid), 8'(exp_v));
`ifdef FA2_PARITY_EN
        check({tag, ".o_par"}, 8'(o_par), 8'(^exp_q));
`endif
    endtask

    initial begin
        rst_n = 1'b0;
        drive(2'b00, 2'b00, 1'b0, 1'b0);
        exp_q = '0;
        exp_v = 1'b0;

        #1;
        check("rst.o_q", 8'(o_q), 8'h0);
        check("rst.out_valid", 8'(out_valid), 8'h0);
        check("zero.o", 8'(o), 8'h0);

        drive(2'b00, 2'b01, 1'b0, 1'b0); #5; check("comb0", 8'(o), 8'h1);
        drive(2'b10, 2'b01, 1'b0, 1'b0); #5; check("comb1", 8'(o), 8'h3);
        drive(2'b01, 2'b11, 1'b0, 1'b0); #5; check("comb2", 8'(o), 8'h4);
        drive(2'b11, 2'b11, 1'b0, 1'b0); #5; check("comb3", 8'(o), 8'h6);
        drive(2'b00, 2'b01, 1'b0, 1'b0); #5; check("comb4", 8'(o), 8'h1);
        drive(2'b11, 2'b11, 1'b1, 1'b0); #5; check("cin_max", 8'(o), 8'h7);
        drive(2'b00, 2'b00, 1'b1, 1'b0); #5; check("cin_zero", 8'(o), 8'h1);

        @(negedge clk);
        rst_n = 1'b1;

        cycle("cap", 2'b10, 2'b01, 1'b0, 1'b1);
        check("cap.val", 8'(o_q), 8'h3);
        cycle("hold", 2'b11, 2'b11, 1'b0, 1'b0);
        check("hold.val", 8'(o_q), 8'h3);

        cycle("s0", 2'b01, 2'b11, 1'b0, 1'b1);
        check("s0.val", 8'(o_q), 8'h4);
        cycle("s1", 2'b11, 2'b11, 1'b0, 1'b1);
        check("s1.val", 8'(o_q), 8'h6);
        cycle("s2", 2'b00, 2'b01, 1'b0, 1'b1);
        check("s2.val", 8'(o_q), 8'h1);
        cycle("s3", 2'b11, 2'b11, 1'b0, 1'b1);
        check("s3.val", 8'(o_q), 8'h6);

        // Mid-cycle reset: registered side clears at once, o keeps tracking.
        @(negedge clk);
        drive(2'b10, 2'b11, 1'b1, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        exp_q = '0;
        exp_v = 1'b0;
        check("arst.o_q", 8'(o_q), 8'h0);
        check("arst.out_valid", 8'(out_valid), 8'h0);
        check("arst.o", 8'(o), 8'h6);
        drive(2'b01, 2'b01, 1'b0, 1'b1);
        #1;
        check("arst.o_track", 8'(o), 8'h2);
        @(posedge clk);
        #1;
        check("arst.hold_q", 8'(o_q), 8'h0);
        check("arst.hold_v", 8'(out_valid), 8'h0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 60; i++) begin
            cycle("rnd", W'($urandom), W'($urandom), 1'($urandom),
                  ($urandom_range(0, 3) != 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fa_2_adder.md
Name: fa_2_adder

Overview:
- Parameterised ripple-carry adder; default width 2 bits.
- Adds two unsigned operands and produces a (WIDTH+1)-bit result, carry-out as the MSB.
- Offers a combinational result path and a 1-cycle registered result path with a valid flag.
- Used as a small arithmetic leaf cell in datapaths and as a bring-up / waveform-dump target.

Parameters:
- WIDTH, 2: operand width in bits; must be >= 1.

Ports:
- clk  input  1  rising-edge clock for the registered path
- rst_n  input  1  asynchronous active-low reset
- a  input  WIDTH  operand A, unsigned
- b  input  WIDTH  operand B, unsigned
- cin  input  1  carry-in; tie to 0 for a plain A+B
- in_valid  input  1  qualifies a, b and cin for capture into the registered path
- o  output  WIDTH+1  combinational sum a+b+cin; o[WIDTH] is the carry-out
- o_q  output  WIDTH+1  registered sum
- out_valid  output  1  o_q was updated on the last rising edge

Behaviour:
- Arithmetic
  - o = a + b + cin, unsigned.
  - The result is computed at full WIDTH+1 precision, so no overflow or truncation is possible.
  - Maximum value is 2*(2^WIDTH - 1) + 1.
- Structure
  - WIDTH chained 1-bit full-adder cells. Each cell computes s = x^y^c and co = (x&y)|(c&(x^y)).
  - Bit i carry-in is the carry-out of bit i-1; bit 0 takes cin.
  - o[WIDTH] is the final carry-out.
- Combinational path
  - o is purely combinational and has no dependence on clk or rst_n.
  - o settles within one propagation delay of any input change, including during reset.
- Registered path
  - Latency 1 cycle.
  - On a rising clk edge with in_valid=1: o_q <= current o, and out_valid <= 1.
  - On a rising clk edge with in_valid=0: o_q holds its value, and out_valid <= 0.
  - Back-to-back in_valid is supported at full throughput: one result per cycle, no stall and no backpressure.
- Reset
  - rst_n=0 immediately, without waiting for clk, forces o_q=0 and out_valid=0.
  - Deassertion is synchronised externally. The first capture can occur on the first rising edge after rst_n goes high.
  - Reset asserted mid-stream discards any pending result; out_valid drops at once.
- Boundary conditions
  - All-zero inputs give o=0.
  - All-ones inputs with cin=1 give o = 2^(WIDTH+1) - 1, which is 3'b111 for WIDTH=2.
  - X on any input propagates to o. o_q captures it only when in_valid=1.

Optional Feature:
- Macro: FA2_PARITY_EN.
- Defined:
  - Adds an output port o_par (1 bit) equal to the XOR-reduction of o_q.
  - o_par is registered alongside o_q, updates under the same in_valid rule, and resets to 0.
- Undefined:
  - Port o_par does not exist and no parity logic is generated.
  - All other behaviour is identical.

Test Plan:
- WIDTH=2, cin=0, combinational path only: apply a=00,b=01 then a=10,b=01 then a=01,b=11 then a=11,b=11, holding each for 5 time units -> o = 001, 011, 100, 110 respectively; finally a=00,b=01 -> o returns to 001.
- Carry-in: a=11, b=11, cin=1 -> o=111. Then a=00, b=00, cin=1 -> o=001.
- Registered path: hold rst_n=0, then release. Drive in_valid=1 with a=10,b=01 for one edge, then in_valid=0 -> after the edge, o_q=011 and out_valid=1. On the next edge out_valid=0 and o_q remains 011.
- Streaming: in_valid=1 on consecutive edges with (01,11), (11,11), (00,01) -> o_q = 100, 110, 001 on successive cycles, with out_valid held at 1.
- Async reset: after o_q=110, pull rst_n low between clock edges -> o_q=000 and out_valid=0 immediately, while o still tracks the inputs.
- FA2_PARITY_EN defined: capture a=01,b=11 (o_q=100) -> o_par=1. Capture a=11,b=11 (o_q=110) -> o_par=0.
